// File: rtl/gsim_pkg.sv
// Shared definitions for the GSIM matrix-memory server: state encoding, lane geometry
// and the rows-per-matrix constant used for solver address generation.
package gsim_pkg;

  typedef enum logic [1:0] {
    ST_WAKE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_REFRESH = 2'd2
  } state_e;

  localparam int unsigned LANE_W       = 16;
  localparam int unsigned LANE_N       = 16;
  localparam int unsigned ROWS_PER_MAT = 17;

  // Row address of row 'row' of matrix 'mat' in the store.
  function automatic int unsigned row_addr(input int unsigned mat, input int unsigned row);
    return ROWS_PER_MAT * mat + row;
  endfunction

endpackage

// File: rtl/gsim_mat_mem_server_if.sv
// Solver-facing read bus of the matrix store: request/ready handshake plus
// fixed-latency data beat.
interface gsim_mat_mem_server_if
  import gsim_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = LANE_W * LANE_N
) ();

  logic              mem_rreq;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rrdy;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_dout_vld;

  modport master (
    output mem_rreq,
    output mem_addr,
    input  mem_rrdy,
    input  mem_dout,
    input  mem_dout_vld
  );

  modport slave (
    input  mem_rreq,
    input  mem_addr,
    output mem_rrdy,
    output mem_dout,
    output mem_dout_vld
  );

endinterface

// File: rtl/gsim_mat_sram.sv
// Single-port behavioural matrix array: 1-cycle synchronous read, write-first, no reset.
module gsim_mat_sram
  import gsim_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = LANE_W * LANE_N
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
        r_rdata       <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gsim_mat_mem_server.sv
// Responder for the GSIM matrix-memory read bus: fixed-latency reads with ready
// back-pressure during host loads and periodic refresh windows.
module gsim_mat_mem_server
  import gsim_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = LANE_W * LANE_N,
  parameter int unsigned READ_LAT       = 2,
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  gsim_mat_mem_server_if.slave   io_mem,
  input  logic                   i_ld_wen,
  input  logic [ADDR_W-1:0]      i_ld_addr,
  input  logic [DATA_W-1:0]      i_ld_data,
  output logic                   o_busy
);

  localparam int unsigned CNT_MAX =
    (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
  localparam int unsigned CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PERIOD_LAST =
    CNT_W'((REFRESH_PERIOD == 0) ? 0 : REFRESH_PERIOD - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [ADDR_W:0]  DEPTH_LIM    = (ADDR_W + 1)'(DEPTH);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_rrdy;
  logic              w_accept;
  logic              w_rd_oor;
  logic              w_wr_en;
  logic              w_ram_en;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_s0_data;
  logic [DATA_W-1:0] w_last_data;
  logic              w_last_vld;
  logic [READ_LAT-1:0] r_vld;
  logic              r_oor;
  logic [DATA_W-1:0] r_hold;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_WAKE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM: next state; r_cnt counts SERVE cycles, then refresh cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_WAKE: begin
        w_state_nxt = ST_SERVE;
        w_cnt_nxt   = '0;
      end
      ST_SERVE: begin
        if (REFRESH_PERIOD != 0) begin
          if (r_cnt == PERIOD_LAST) begin
            w_state_nxt = ST_REFRESH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_REFRESH: begin
        if (r_cnt == REFRESH_LAST) begin
          w_state_nxt = ST_SERVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WAKE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM: outputs; a host load always wins over a read in the same cycle
  always_comb begin
    w_rrdy = 1'b0;
    if (r_state == ST_SERVE) begin
      w_rrdy = !i_ld_wen;
    end
  end

  assign io_mem.mem_rrdy = w_rrdy;

  assign w_accept   = io_mem.mem_rreq & w_rrdy;
  assign w_rd_oor   = ({1'b0, io_mem.mem_addr} >= DEPTH_LIM);
  assign w_wr_en    = i_ld_wen && (r_state != ST_WAKE) && ({1'b0, i_ld_addr} < DEPTH_LIM);
  assign w_ram_en   = w_wr_en | (w_accept & ~w_rd_oor);
  assign w_ram_addr = i_ld_wen ? i_ld_addr : io_mem.mem_addr;

  gsim_mat_sram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (w_wr_en),
    .i_addr  (w_ram_addr),
    .i_wdata (i_ld_data),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_oor <= 1'b0;
    end else begin
      r_vld[0] <= w_accept;
      for (int k = 1; k < int'(READ_LAT); k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      if (w_accept) begin
        r_oor <= w_rd_oor;
      end
    end
  end

  // Out-of-range reads never touch the array; their beat is forced to zero here.
  assign w_s0_data = r_oor ? '0 : w_ram_rdata;

  if (READ_LAT == 1) begin : g_lat1
    assign w_last_data = w_s0_data;
  end else begin : g_latn
    logic [DATA_W-1:0] r_dat [READ_LAT-1];

    always_ff @(posedge i_clk) begin
      r_dat[0] <= w_s0_data;
      for (int k = 1; k < int'(READ_LAT) - 1; k++) begin
        r_dat[k] <= r_dat[k-1];
      end
    end

    assign w_last_data = r_dat[READ_LAT-2];
  end

  assign w_last_vld = r_vld[READ_LAT-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
    end else if (w_last_vld) begin
      r_hold <= w_last_data;
    end
  end

  assign io_mem.mem_dout     = w_last_vld ? w_last_data : r_hold;
  assign io_mem.mem_dout_vld = w_last_vld;
  assign o_busy              = |r_vld;

endmodule

// File: tb/tb_gsim_mat_mem_server.sv
// Scoreboard bench: DUT A (lat 2, refresh 8/2, depth 1000) and lockstep DUTs B/C
// (lat 1 and lat 4, no refresh) share one clock and reset.
module tb_gsim_mat_mem_server;
  import gsim_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 256;

  typedef logic [DW-1:0] word_t;
  typedef struct {
    word_t d;
    int    due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // -1 during reset and the wake cycle, then number of cycles since serving began
  int sv = -1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sv = -1;
    else        sv = sv + 1;
  end

  int checks = 0;
  int failures = 0;

  gsim_mat_mem_server_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  gsim_mat_mem_server_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
  gsim_mat_mem_server_if #(.ADDR_W(AW), .DATA_W(DW)) bus_c ();

  assign bus_c.mem_rreq = bus_b.mem_rreq;
  assign bus_c.mem_addr = bus_b.mem_addr;

  logic          a_ldw = 1'b0, b_ldw = 1'b0;
  logic [AW-1:0] a_lda = '0, b_lda = '0;
  word_t         a_ldd = '0, b_ldd = '0;
  logic          a_busy, b_busy, c_busy;

  gsim_mat_mem_server #(
    .DEPTH(1000), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(2),
    .REFRESH_PERIOD(8), .REFRESH_CYCLES(2)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .io_mem(bus_a),
    .i_ld_wen(a_ldw), .i_ld_addr(a_lda), .i_ld_data(a_ldd), .o_busy(a_busy)
  );

  gsim_mat_mem_server #(
    .DEPTH(1024), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1),
    .REFRESH_PERIOD(0), .REFRESH_CYCLES(2)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .io_mem(bus_b),
    .i_ld_wen(b_ldw), .i_ld_addr(b_lda), .i_ld_data(b_ldd), .o_busy(b_busy)
  );

  gsim_mat_mem_server #(
    .DEPTH(1024), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(4),
    .REFRESH_PERIOD(0), .REFRESH_CYCLES(2)
  ) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .io_mem(bus_c),
    .i_ld_wen(b_ldw), .i_ld_addr(b_lda), .i_ld_data(b_ldd), .o_busy(c_busy)
  );

  word_t ma [1024];
  word_t mb [1024];
  exp_t  qa [$];
  exp_t  qb [$];
  exp_t  qc [$];
  word_t lastv [3];

  function automatic word_t pat(input int k, input int base);
    word_t w;
    for (int i = 0; i < 16; i++) w[16*i +: 16] = 16'(base + k * 16 + i);
    return w;
  endfunction

  task automatic chk1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, got, want);
    end
  endtask

  task automatic pop(input int id);
    case (id)
      0:       qa.delete(0);
      1:       qb.delete(0);
      default: qc.delete(0);
    endcase
  endtask

  task automatic mon(input int id, input logic vld, input word_t dout, input logic busy);
    exp_t e;
    bit   have;
    have = 0;
    case (id)
      0:       if (qa.size() > 0) begin e = qa[0]; have = 1; end
      1:       if (qb.size() > 0) begin e = qb[0]; have = 1; end
      default: if (qc.size() > 0) begin e = qc[0]; have = 1; end
    endcase
    chk1($sformatf("busy_dut%0d", id), busy, have);
    if (vld === 1'b1) begin
      checks++;
      if (!have) begin
        failures++;
        $display("FAIL spurious_vld dut%0d cyc=%0d got vld=1 want no beat", id, cyc);
      end else begin
        pop(id);
        if (dout !== e.d || cyc != e.due) begin
          failures++;
          $display("FAIL beat dut%0d got %h at cyc %0d want %h at cyc %0d",
                   id, dout, cyc, e.d, e.due);
        end
        lastv[id] = e.d;
      end
    end else begin
      if (have && e.due <= cyc) begin
        pop(id);
        checks++;
        failures++;
        $display("FAIL missing_vld dut%0d cyc=%0d got vld=%b want beat due %0d",
                 id, cyc, vld, e.due);
      end
      checks++;
      if (dout !== lastv[id]) begin
        failures++;
        $display("FAIL dout_hold dut%0d cyc=%0d got %h want %h", id, cyc, dout, lastv[id]);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.mem_dout_vld, bus_a.mem_dout, a_busy);
    mon(1, bus_b.mem_dout_vld, bus_b.mem_dout, b_busy);
    mon(2, bus_c.mem_dout_vld, bus_c.mem_dout, c_busy);
  end

  // Drives one cycle on DUT A; decides acceptance from the refresh schedule model.
  task automatic step_a(input logic rq, input logic [AW-1:0] ad, input logic lw,
                        input logic [AW-1:0] la, input word_t ld, output bit acc);
    bit   exp_rdy;
    exp_t e;
    bus_a.mem_rreq = rq;
    bus_a.mem_addr = ad;
    a_ldw = lw;
    a_lda = la;
    a_ldd = ld;
    @(negedge clk);
    #2;
    exp_rdy = (sv >= 0) && ((sv % 10) < 8) && !lw;
    chk1("rrdy_a", bus_a.mem_rrdy, exp_rdy);
    acc = rq && exp_rdy;
    if (acc) begin
      e.d   = (ad >= 10'd1000) ? word_t'(0) : ma[ad];
      e.due = cyc + 2;
      qa.push_back(e);
    end
    if (lw && sv >= 0 && la < 10'd1000) ma[la] = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic rq, input logic [AW-1:0] ad, input logic lw,
                        input logic [AW-1:0] la, input word_t ld, output bit acc);
    bit   exp_rdy;
    exp_t e;
    bus_b.mem_rreq = rq;
    bus_b.mem_addr = ad;
    b_ldw = lw;
    b_lda = la;
    b_ldd = ld;
    @(negedge clk);
    #2;
    exp_rdy = (sv >= 0) && !lw;
    chk1("rrdy_b", bus_b.mem_rrdy, exp_rdy);
    chk1("rrdy_c", bus_c.mem_rrdy, exp_rdy);
    acc = rq && exp_rdy;
    if (acc) begin
      e.d   = mb[ad];
      e.due = cyc + 1;
      qb.push_back(e);
      e.due = cyc + 4;
      qc.push_back(e);
    end
    if (lw && sv >= 0) mb[la] = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step_a(1'b0, '0, 1'b0, '0, '0, acc);
  endtask

  task automatic a_read(input logic [AW-1:0] ad);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      step_a(1'b1, ad, 1'b0, '0, '0, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL a_read_timeout addr=%0d got no accept want accept within 20", ad);
    end
    bus_a.mem_rreq = 1'b0;
  endtask

  initial begin
    bit acc;
    int addr;
    bus_a.mem_rreq = 1'b0;
    bus_a.mem_addr = '0;
    bus_b.mem_rreq = 1'b0;
    bus_b.mem_addr = '0;
    for (int i = 0; i < 3; i++) lastv[i] = '0;

    @(posedge clk);
    #1;
    idle_a(2);
    rst_n = 1'b1;
    step_a(1'b1, 10'd3, 1'b0, '0, '0, acc);     // wake cycle: not ready

    for (int k = 0; k <= 16; k++) step_a(1'b0, '0, 1'b1, AW'(k), pat(k, 0), acc);
    for (int k = 0; k < 8; k++) step_b(1'b0, '0, 1'b1, AW'(k), pat(k, 'h100), acc);

    a_read(10'd5);                              // lane 3 = 16'h0053
    idle_a(3);

    addr = 0;
    for (int n = 0; n < 100 && addr <= 16; n++) begin
      step_a(1'b1, AW'(addr), 1'b0, '0, '0, acc);
      if (acc) addr++;
    end
    checks++;
    if (addr <= 16) begin
      failures++;
      $display("FAIL burst_a got %0d accepts want 17", addr);
    end
    idle_a(3);

    step_a(1'b1, 10'd9, 1'b1, 10'd9, '1, acc);  // load wins, rrdy must be 0
    a_read(10'd9);
    idle_a(3);

    a_read(10'd1023);
    step_a(1'b0, '0, 1'b1, 10'd1010, '1, acc);
    a_read(10'd1010);
    idle_a(5);

    step_b(1'b1, 10'd3, 1'b0, '0, '0, acc);
    step_b(1'b1, 10'd0, 1'b0, '0, '0, acc);
    step_b(1'b1, 10'd7, 1'b0, '0, '0, acc);
    step_b(1'b1, 10'd5, 1'b0, '0, '0, acc);
    for (int i = 0; i < 6; i++) step_b(1'b0, '0, 1'b0, '0, '0, acc);
    step_b(1'b0, '0, 1'b1, 10'd2, pat(2, 'h777), acc);
    step_b(1'b1, 10'd2, 1'b0, '0, '0, acc);
    for (int i = 0; i < 6; i++) step_b(1'b0, '0, 1'b0, '0, '0, acc);

    a_read(10'd2);
    rst_n = 1'b0;                               // one cycle after the accept
    qa.delete();
    qb.delete();
    qc.delete();
    for (int i = 0; i < 3; i++) lastv[i] = '0;
    idle_a(2);
    rst_n = 1'b1;
    step_a(1'b1, 10'd2, 1'b1, 10'd5, pat(5, 'h999), acc);  // wake: write dropped
    a_read(10'd2);
    a_read(10'd5);
    idle_a(2);

    for (int n = 0; n < 20 && (qa.size() + qb.size() + qc.size()) > 0; n++) idle_a(1);
    checks++;
    if ((qa.size() + qb.size() + qc.size()) > 0) begin
      failures++;
      $display("FAIL drain got %0d beats outstanding want 0", qa.size() + qb.size() + qc.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gsim_mat_mem_server.md
Name: gsim_mat_mem_server

Overview:
- Responder side of the GSIM matrix-memory read interface. Serves 256-bit rows (16 lanes of 16-bit signed matrix, b and 1/a_ii data) to the solver.
- Fixed read latency, with `o_mem_rrdy` back-pressure during load and refresh windows.
- Also owns a host load port used to fill the matrix store before `i_module_en` is raised.
- Sits between the GSIM solver and the matrix storage array.

Parameters:
- DEPTH, 1024, number of 256-bit words (`i_matrix_num` × 17 rows max must fit).
- ADDR_W, 10, address width.
- DATA_W, 256, word width; lane i occupies bits [16i+15:16i].
- READ_LAT, 2, cycles from accepted request to `o_mem_dout_vld`; legal range 1..4.
- REFRESH_PERIOD, 64, SERVE cycles between refresh windows; 0 disables refresh.
- REFRESH_CYCLES, 2, length of each refresh window in cycles; legal range ≥1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mem_rreq  in  1  read request from solver
- i_mem_addr  in  ADDR_W  read address
- o_mem_rrdy  out  1  request accepted this cycle when high with i_mem_rreq
- o_mem_dout  out  DATA_W  read data
- o_mem_dout_vld  out  1  o_mem_dout valid, one-cycle pulse per accepted request
- i_ld_wen  in  1  host write strobe
- i_ld_addr  in  ADDR_W  host write address
- i_ld_data  in  DATA_W  host write data
- o_busy  out  1  high while any accepted read is still in flight

Behaviour:
- One clock. Reset is asynchronous and active-low (`i_rst_n`).
- Reset values:
  - state = ST_WAKE
  - o_mem_rrdy = 0, o_mem_dout_vld = 0, o_mem_dout = 0, o_busy = 0
  - pipeline valids and refresh counter cleared
  - array contents are not reset.
- States:
  - ST_WAKE: entered by reset; lasts exactly one cycle after `i_rst_n` rises, then goes to ST_SERVE.
  - ST_SERVE: `o_mem_rrdy = !i_ld_wen` (combinational).
  - ST_REFRESH: `o_mem_rrdy = 0`; after REFRESH_CYCLES cycles returns to ST_SERVE.
- Refresh counter:
  - Counts cycles spent in ST_SERVE.
  - At count REFRESH_PERIOD-1 the next state is ST_REFRESH and the counter clears.
  - With REFRESH_PERIOD = 0 the block never leaves ST_SERVE.
- Accept = `i_mem_rreq & o_mem_rrdy`.
  - Address is sampled on the accept edge.
  - Data appears with `o_mem_dout_vld = 1` exactly READ_LAT cycles later.
  - Back-to-back accepts give back-to-back valid beats.
  - No response back-pressure: the solver must take every beat.
- Requests already in the pipeline when refresh starts still complete at their original latency. Refresh only blocks new accepts.
- `o_mem_dout` holds the last valid word while `o_mem_dout_vld = 0`.
- Load port:
  - `i_ld_wen` writes `i_ld_data` at `i_ld_addr` on the clock edge.
  - It is honoured in every state except ST_WAKE; writes during ST_WAKE are dropped.
  - A load in the same cycle as a pending rreq wins, and rrdy is 0 that cycle.
- Read after write to the same address, issued on the next cycle, returns the new data. A same-cycle conflict cannot occur because of the priority rule.
- Addresses ≥ DEPTH:
  - Reads are accepted and return all-zero data with normal latency and valid.
  - Writes to those addresses are ignored.
- `o_busy` = OR of pipeline valid bits, registered.
- Assertion of `i_rst_n = 0` mid-transfer drops all in-flight reads immediately; no `o_mem_dout_vld` is produced for them.
- `i_mem_addr` may change combinationally while rrdy = 0; only the value at accept matters.

Decomposition:
- Shared package `gsim_pkg` holds:
  - state encoding ST_WAKE / ST_SERVE / ST_REFRESH
  - lane width 16 and lane count 16
  - the rows-per-matrix constant 17, used with the solver for address generation `17*mat + row`.
- One sub-module, `gsim_mat_sram`: single-port behavioural array.
  - 1-cycle synchronous read, write-first, no reset.
  - Instantiated once.
  - The remaining READ_LAT-1 stages are registers in the top module.

Test Plan:
- Load addr 0..16 with word k having lane i = 16'(k*16+i); request addr 5 once → `o_mem_dout_vld` exactly 2 cycles after accept; lane 3 = 16'h0053.
- Hold rreq = 1 and step addr 0..16 every accepted cycle, with REFRESH_PERIOD = 8 and REFRESH_CYCLES = 2 → rrdy drops for 2 cycles after every 8 SERVE cycles. All 17 beats arrive in order, each at latency 2, and no beat is duplicated or lost.
- `i_ld_wen` = 1 to addr 9 with data all-1s, concurrent with rreq on addr 9 → rrdy = 0 that cycle; the read accepted next cycle returns all-1s.
- Read addr 1023 (DEPTH = 1000) → valid after 2 cycles with data 0. A write to addr 1010 is ignored, so a later read of 1010 also returns 0.
- Pull `i_rst_n` low one cycle after an accept → no dout_vld pulse. After release, rrdy = 0 for one cycle (ST_WAKE) and then 1; array contents are preserved.
- READ_LAT = 1 and READ_LAT = 4 builds with a back-to-back 4-request burst → latency is exactly 1 or 4 respectively, and `o_busy` is high from the first accept until the cycle of the last vld.
